muldiv_ctrl: RTL
================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL: ITER_STEPS, default 32, iteration cycles per operation (fixed at 32; not configurable).
REQ-002 SHALL: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL: reset  input  1  synchronous, active-high; sampled on rising clock edge.
REQ-004 SHALL: start  input  1  request new HI/LO operation from decode.
REQ-005 SHALL: op  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 SHALL: rs_data  input  32  multiplicand / dividend.
REQ-007 SHALL: rt_data  input  32  multiplier / divisor.
REQ-008 SHALL: mf_req  input  1  decode holds mfhi/mflo and needs HI/LO.
REQ-009 SHALL: busy  output  1  operation in progress.
REQ-010 SHALL: done  output  1  one-cycle pulse; HI/LO hold new result.
REQ-011 SHALL: stall  output  1  freeze decode; combinational: busy & (start | mf_req).
REQ-012 SHALL: hi  output  32  HI register, registered.
REQ-013 SHALL: lo  output  32  LO register, registered.

Function
REQ-014 SHALL: states IDLE, ITER, SIGN; IDLE->ITER on start; ITER->SIGN after 32nd step; SIGN->IDLE always.
REQ-015 SHALL: start accepted only in IDLE; operands and op latched at the accepting edge (E0).
REQ-016 SHALL: start while busy ignored, no queuing; latched operands unaffected.
REQ-017 SHALL: ITER does one step per cycle, 5-bit counter 0..31; SIGN applies sign correction and writes hi/lo at edge E33.
REQ-018 SHALL: busy high from cycle after E0 through cycle ending at E33; low in done cycle.
REQ-019 SHALL: done high exactly the one cycle after E33; new start accepted in that cycle (back-to-back).
REQ-020 SHALL: multu: unsigned 64-bit product via shift-add; hi=product[63:32], lo=product[31:0].
REQ-021 SHALL: mult: operand magnitudes multiplied; 64-bit result negated when operand signs differ.
REQ-022 SHALL: divu: restoring division; lo=quotient, hi=remainder.
REQ-023 SHALL: div: magnitude division; quotient truncates toward zero, negated when signs differ; remainder takes dividend sign.
REQ-024 SHALL: divisor zero, div or divu: hi=rs_data, lo=32'hFFFFFFFF, same 34-cycle latency.
REQ-025 SHALL: div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no exception.
REQ-026 SHALL: hi/lo unchanged except at SIGN or reset; mf_req while not busy gives stall=0 and current hi/lo.
REQ-027 SHALL: start and mf_req together in IDLE: stall=0, mf reads pre-operation hi/lo, operation starts.

Reset
REQ-028 SHALL: reset forces IDLE, counter=0, busy=0, done=0, hi=0, lo=0 at next edge.
REQ-029 SHALL: reset mid-operation (ITER or SIGN) abandons it: no done pulse, no hi/lo write.
REQ-030 SHALL: reset takes priority over simultaneous start; start in reset cycle discarded.

Verification
REQ-031 SHALL: multu rs=0xFFFFFFFF rt=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001, done in cycle after E33, busy 33 cycles.
REQ-032 SHALL: mult rs=0xFFFFFFFD rt=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; back-to-back start in done cycle accepted.
REQ-033 SHALL: div rs=0xFFFFFFF9 rt=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; divu rs=7 rt=0 -> hi=7 lo=0xFFFFFFFF.
REQ-034 SHALL: div rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-035 SHALL: start (multu 3x4) at cycle 5 of running divu 100/7 ignored; mf_req then gives stall=1; result hi=2 lo=14 only.
REQ-036 SHALL: reset at ITER cycle 10 of div -> busy=0, hi=lo=0, no done; following multu 6x7 gives lo=42 hi=0.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply-divide unit: 32-step shift-add multiply / restoring divide, then one sign-fix cycle.
// Latency: start edge to HI/LO write is 33 edges; done pulses the cycle after. Starts while busy are dropped.
module muldiv_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mf_req,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int         ITER_STEPS = 32;
    localparam logic [4:0] LAST_STEP  = 5'(ITER_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_SIGN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_done;
    logic [31:0] r_rs;
    logic [31:0] r_b;
    logic [31:0] r_acc_hi;
    logic [31:0] r_acc_lo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_signed;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_sh;
    logic        w_div_ge;
    logic [31:0] w_div_diff;
    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    // ---------------- operand conditioning ----------------
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_signed = ~op[0];
    assign w_rs_neg = w_signed & rs_data[31];
    assign w_rt_neg = w_signed & rt_data[31];
    assign w_rs_mag = w_rs_neg ? (~rs_data + 32'd1) : rs_data;
    assign w_rt_mag = w_rt_neg ? (~rt_data + 32'd1) : rt_data;

    // ---------------- per-step datapath ----------------
    // Multiply: acc_lo holds the multiplier and shifts right as product bits enter from the top.
    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : 33'd0);

    // Divide: {acc_hi, acc_lo} is {partial remainder, dividend/quotient}; shift left, trial-subtract.
    assign w_div_sh   = {r_acc_hi, r_acc_lo[31]};
    assign w_div_ge   = (w_div_sh >= {1'b0, r_b});
    assign w_div_diff = w_div_sh[31:0] - r_b;

    // ---------------- sign correction ----------------
    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_q ? (~w_prod + 64'd1) : w_prod;
    assign w_quo_fix  = r_neg_q ? (~r_acc_lo + 32'd1) : r_acc_lo;
    assign w_rem_fix  = r_neg_r ? (~r_acc_hi + 32'd1) : r_acc_hi;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_ITER;
            S_ITER:  if (r_cnt == LAST_STEP) w_next_state = S_SIGN;
            S_SIGN:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy  = (r_state == S_ITER) || (r_state == S_SIGN);
        done  = r_done;
        stall = busy && (start || mf_req);
        hi    = r_hi;
        lo    = r_lo;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= 5'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_rs     <= 32'd0;
            r_b      <= 32'd0;
            r_acc_hi <= 32'd0;
            r_acc_lo <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_done <= (r_state == S_SIGN);

            if (w_accept) begin
                r_cnt    <= 5'd0;
                r_is_div <= op[1];
                r_neg_q  <= w_rs_neg ^ w_rt_neg;
                r_neg_r  <= w_rs_neg;
                r_rs     <= rs_data;
                r_b      <= op[1] ? w_rt_mag : w_rs_mag;
                r_acc_hi <= 32'd0;
                r_acc_lo <= op[1] ? w_rs_mag : w_rt_mag;
            end

            if (r_state == S_ITER) begin
                r_cnt <= r_cnt + 5'd1;
                if (r_is_div) begin
                    r_acc_hi <= w_div_ge ? w_div_diff : w_div_sh[31:0];
                    r_acc_lo <= {r_acc_lo[30:0], w_div_ge};
                end else begin
                    r_acc_hi <= w_mul_sum[32:1];
                    r_acc_lo <= {w_mul_sum[0], r_acc_lo[31:1]};
                end
            end

            // A zero divisor still runs the full iteration so latency never depends on operands.
            if (r_state == S_SIGN) begin
                if (!r_is_div) begin
                    r_hi <= w_prod_fix[63:32];
                    r_lo <= w_prod_fix[31:0];
                end else if (r_b == 32'd0) begin
                    r_hi <= r_rs;
                    r_lo <= 32'hFFFF_FFFF;
                end else begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end
            end
        end
    end

endmodule
